gain_cmd_writer: RTL and testbench
==================================

# gain_cmd_writer

Frame-parsing write initiator for the equalizer gain register bank. Accepts a byte stream from the host link (UART/SPI receiver) over a valid/ready handshake, validates command frames (header, command, payload, XOR checksum, address range, inter-byte timeout), and drives the bank's `we`/`addr`/`data_in` write port. Supports single-band writes and broadcast writes to all bands. It is the only writer of the gain bank.

## Interface
- `NUM_BANDS`, 10, number of gain registers; valid addresses are 0..NUM_BANDS-1.
- `TIMEOUT_CYCLES`, 100000, maximum idle cycles allowed between bytes inside a frame.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  block can accept a byte; a byte transfers when `rx_valid && rx_ready` on a rising edge.
- `we`  out  1  write strike to the gain bank, one cycle per write.
- `addr`  out  8  bank address; meaningful only when `we` is 1.
- `data_out`  out  8  raw gain byte for the bank's `data_in`; meaningful only when `we` is 1.
- `frame_ok`  out  1  one-cycle pulse marking a completed valid frame.
- `frame_err`  out  1  one-cycle pulse marking a rejected frame.
- `err_count`  out  8  saturating count of rejected frames.

## Operation
- Frame formats:
  - Single write: `A5, 01, addr, data, csum`, where `csum = 01^addr^data`.
  - Broadcast: `A5, 02, data, csum`, where `csum = 02^data`.
- FSM states: IDLE, CMD, ADDR, DATA, CSUM, WRITE, BCAST. Reset state is IDLE.
- IDLE: non-A5 bytes are discarded silently; no error is raised. A5 moves to CMD.
- CMD: 01 moves to ADDR. 02 moves to DATA, with `addr` latched as 0. Any other value raises an error and returns to IDLE.
- ADDR: latch `addr`, move to DATA.
- DATA: latch `data_out`, move to CSUM.
- CSUM behaviour:
  - On mismatch, or on a single write with `addr >= NUM_BANDS`, raise an error and return to IDLE. No write is issued.
  - Otherwise go to WRITE (single write) or BCAST (broadcast).
- Running XOR register: cleared on A5, updated on each accepted CMD/ADDR/DATA byte, and compared against the CSUM byte.
- WRITE: `we=1` for one cycle and `frame_ok=1` in the same cycle, then return to IDLE.
- BCAST: `we=1` for NUM_BANDS consecutive cycles, with `addr` stepping 0..NUM_BANDS-1 and `data_out` held. `frame_ok=1` on the last of these cycles, then return to IDLE.
- `rx_ready` is 1 in IDLE/CMD/ADDR/DATA/CSUM and 0 in WRITE/BCAST.
- Timeout:
  - The idle counter runs in CMD..CSUM and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES-1` with no byte accepted, raise an error and return to IDLE.
  - The counter is held at 0 in IDLE.
- Error behaviour: `frame_err` pulses for one cycle and `err_count` increments, saturating at 255.
- A5 appearing inside a frame is treated as ordinary data. There is no resynchronisation except through an error or timeout.

## Timing
- Reset values: `we`=0, `addr`=0, `data_out`=0, `frame_ok`=0, `frame_err`=0, `err_count`=0, `rx_ready`=1 (IDLE).
- All outputs are registered, except `rx_ready`, which is a decode of the state.
- Write latency: `we` rises on the cycle immediately after the edge that accepts the CSUM byte.
- Frame throughput:
  - A single-write frame occupies at least 6 cycles (5 bytes plus WRITE).
  - A broadcast occupies at least 4+NUM_BANDS cycles.
- `frame_err` for a checksum or address error asserts on the cycle after the CSUM byte is accepted. For a bad CMD, it asserts on the cycle after the CMD byte.
- Reset mid-operation (including mid-BCAST): `we` drops asynchronously and the FSM restarts in IDLE. Partial broadcasts are not resumed.
- `rx_valid` held high continuously is legal; bytes are consumed back-to-back in the receiving states.

## Structure
- Shared package `eq_cmd_pkg` holds:
  - `HDR_BYTE`=8'hA5, `CMD_WR`=8'h01, `CMD_BCAST`=8'h02;
  - the FSM state encoding;
  - `GAIN_BYTE_W`=8.
- Natural sub-module: `byte_timeout` (idle counter with clear and enable, producing an expiry pulse), parameterised by `TIMEOUT_CYCLES`.
- Top level connects `we`, `addr` and `data_out` directly to the gain bank's `we`, `addr` and `data_in`.

## Test plan
- Single write: stream `A5 01 03 40 42`. Expect exactly one `we` cycle with `addr`=3 and `data_out`=8'h40, a `frame_ok` pulse, and `err_count`=0.
- Broadcast: stream `A5 02 20 22`. Expect 10 consecutive `we` cycles with `addr` 0..9 and `data_out`=8'h20, `rx_ready`=0 throughout, and `frame_ok` on `addr`=9.
- Bad checksum: stream `A5 01 03 40 00`. Expect no `we`, one `frame_err`, and `err_count`=1. Then stream a valid `A5 01 03 40 42`. Expect it to be accepted normally.
- Out-of-range address: stream `A5 01 0A 40 4B` with NUM_BANDS=10. Expect no `we` and a `frame_err`. Stream `A5 07` (bad command). Expect an immediate `frame_err` and `err_count`=2.
- Timeout: with TIMEOUT_CYCLES=16, send `A5 01` and then nothing for 16 cycles. Expect `frame_err` and a return to IDLE. A following valid frame must write. Also stream garbage `00 FF 13` while in IDLE. Expect no error.
- Reset mid-broadcast: assert `rst`=0 during the 4th `we` cycle of a broadcast. Expect `we`=0 immediately and all outputs at reset values. After release, a single write is accepted.

Source files
------------

// File: rtl/eq_cmd_pkg.sv
// Shared constants for the equalizer gain command path:
// frame marker bytes, command-parser state encoding and gain byte width.
package eq_cmd_pkg;

    localparam int GAIN_BYTE_W = 8;

    localparam logic [7:0] HDR_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_BCAST = 8'h02;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;
    localparam logic [2:0] ST_BCAST = 3'd6;

endpackage

// File: rtl/gain_cmd_writer_if.sv
// Host byte stream (valid/ready), gain-bank write port and frame status
// seen by the gain command writer.
interface gain_cmd_writer_if;
    import eq_cmd_pkg::*;

    logic [GAIN_BYTE_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   we;
    logic [7:0]             addr;
    logic [GAIN_BYTE_W-1:0] data_out;
    logic                   frame_ok;
    logic                   frame_err;
    logic [7:0]             err_count;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, we, addr, data_out, frame_ok, frame_err, err_count
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, we, addr, data_out, frame_ok, frame_err, err_count
    );

endinterface

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: counts while enabled, clears on every accepted
// byte, and pulses expire on the TIMEOUT_CYCLES-th idle cycle.
module byte_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (cnt_q == LIMIT) begin
            expire = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gain_cmd_writer.sv
// Parses host command frames (single-band or broadcast gain writes), checks
// header/command/checksum/address/timeout, and drives the gain bank write port.
module gain_cmd_writer
    import eq_cmd_pkg::*;
#(
    parameter int NUM_BANDS      = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic               clk,
    input logic               rst,
    gain_cmd_writer_if.master bus
);

    localparam logic [7:0] ADDR_LIMIT = 8'(NUM_BANDS);
    localparam logic [7:0] LAST_ADDR  = 8'(NUM_BANDS - 1);

    logic [2:0]             state_q, state_d;
    logic [7:0]             xor_q, xor_d;
    logic [7:0]             addr_q, addr_d;
    logic [GAIN_BYTE_W-1:0] data_q, data_d;
    logic                   bcast_q, bcast_d;
    logic                   we_q, we_d;
    logic                   ok_q, ok_d;
    logic                   err_q, err_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic fire;
    logic in_frame;
    logic expire;
    logic raise_err;

    assign bus.rx_ready = (state_q != ST_WRITE) && (state_q != ST_BCAST);
    assign fire         = bus.rx_valid && bus.rx_ready;
    assign in_frame     = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                          (state_q == ST_DATA) || (state_q == ST_CSUM);

    byte_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst),
        .en    (in_frame),
        .clr   (fire),
        .expire(expire)
    );

    always_comb begin
        state_d   = state_q;
        xor_d     = xor_q;
        addr_d    = addr_q;
        data_d    = data_q;
        bcast_d   = bcast_q;
        we_d      = 1'b0;
        ok_d      = 1'b0;
        raise_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fire && bus.rx_data == HDR_BYTE) begin
                    xor_d   = '0;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (fire) begin
                    xor_d = xor_q ^ bus.rx_data;
                    if (bus.rx_data == CMD_WR) begin
                        bcast_d = 1'b0;
                        state_d = ST_ADDR;
                    end else if (bus.rx_data == CMD_BCAST) begin
                        bcast_d = 1'b1;
                        addr_d  = '0;
                        state_d = ST_DATA;
                    end else begin
                        raise_err = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_ADDR: begin
                if (fire) begin
                    addr_d  = bus.rx_data;
                    xor_d   = xor_q ^ bus.rx_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fire) begin
                    data_d  = bus.rx_data;
                    xor_d   = xor_q ^ bus.rx_data;
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (fire) begin
                    if (bus.rx_data != xor_q || (!bcast_q && addr_q >= ADDR_LIMIT)) begin
                        raise_err = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        // we/frame_ok are registered, so the first strike is set up here
                        we_d    = 1'b1;
                        ok_d    = bcast_q ? (addr_q == LAST_ADDR) : 1'b1;
                        state_d = bcast_q ? ST_BCAST : ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_BCAST: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    addr_d = addr_q + 8'd1;
                    we_d   = 1'b1;
                    ok_d   = (addr_d == LAST_ADDR);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (expire) begin
            raise_err = 1'b1;
            state_d   = ST_IDLE;
        end

        err_d     = raise_err;
        err_cnt_d = (raise_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            xor_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            bcast_q   <= 1'b0;
            we_q      <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            xor_q     <= xor_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            bcast_q   <= bcast_d;
            we_q      <= we_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.data_out  = data_q;
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;
    assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_gain_cmd_writer.sv
// Self-checking bench for gain_cmd_writer: a frame-level reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_gain_cmd_writer;

    localparam int NB = 10;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gain_cmd_writer_if bus();

    gain_cmd_writer #(
        .NUM_BANDS     (NB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (frame buffer + write queue) ----------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [7:0]  fb[$];
    int unsigned idle = 0;
    logic        m_we = 1'b0, m_ok = 1'b0, m_err = 1'b0;
    logic [7:0]  m_addr = '0, m_data = '0, m_cnt = '0;

    task automatic m_error();
        m_err = 1'b1;
        if (m_cnt != 8'hFF) m_cnt++;
        fb.delete();
        idle = 0;
    endtask

    task automatic m_pop();
        wr_t e;
        e      = wq.pop_front();
        m_we   = 1'b1;
        m_addr = e.a;
        m_data = e.d;
        m_ok   = (wq.size() == 0);
    endtask

    task automatic m_frame_check();
        int unsigned n;
        logic [7:0]  cmd;
        logic [7:0]  x;
        n   = fb.size();
        cmd = fb[1];
        if (n == 2 && cmd != 8'h01 && cmd != 8'h02) begin
            m_error();
        end else if ((cmd == 8'h01 && n == 5) || (cmd == 8'h02 && n == 4)) begin
            x = '0;
            for (int unsigned i = 1; i + 1 < n; i++) x ^= fb[i];
            if (x != fb[n-1] || (cmd == 8'h01 && fb[2] >= NB)) begin
                m_error();
            end else begin
                if (cmd == 8'h01) wq.push_back(wr_t'{a: fb[2], d: fb[3]});
                else for (int unsigned k = 0; k < NB; k++) wq.push_back(wr_t'{a: 8'(k), d: fb[2]});
                fb.delete();
                idle = 0;
                m_pop();
            end
        end
    endtask

    initial begin : model
        logic busy;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_we = 1'b0; m_ok = 1'b0; m_err = 1'b0;
                m_addr = '0; m_data = '0; m_cnt = '0;
                wq.delete(); fb.delete(); idle = 0;
            end else begin
                busy = m_we;
                m_we = 1'b0; m_ok = 1'b0; m_err = 1'b0;
                if (busy) begin
                    if (wq.size() > 0) m_pop();
                end else if (bus.rx_valid) begin
                    if (fb.size() == 0) begin
                        if (bus.rx_data == 8'hA5) fb.push_back(8'hA5);
                    end else begin
                        fb.push_back(bus.rx_data);
                        m_frame_check();
                    end
                    idle = 0;
                end else if (fb.size() > 0) begin
                    idle++;
                    if (idle == TO) m_error();
                end
            end
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    int unsigned cyc = 0;
    int unsigned mon_err_n = 0, mon_ok_n = 0, mon_busy_ready = 0;
    logic [7:0]  mon_addr[$];
    logic [7:0]  mon_data[$];
    int unsigned mon_cyc[$];
    logic [7:0]  mon_ok_addr = '0;

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            check("rx_ready", bus.rx_ready, !m_we);
            check("we", bus.we, m_we);
            if (m_we) begin
                check("addr", bus.addr, m_addr);
                check("data_out", bus.data_out, m_data);
            end
            check("frame_ok", bus.frame_ok, m_ok);
            check("frame_err", bus.frame_err, m_err);
            check("err_count", bus.err_count, m_cnt);
            if (bus.we) begin
                mon_addr.push_back(bus.addr);
                mon_data.push_back(bus.data_out);
                mon_cyc.push_back(cyc);
                if (bus.rx_ready) mon_busy_ready++;
            end
            if (bus.frame_ok) begin
                mon_ok_n++;
                mon_ok_addr = bus.addr;
            end
            if (bus.frame_err) mon_err_n++;
        end
    end

    task automatic clear_mon();
        mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
        mon_err_n = 0; mon_ok_n = 0; mon_busy_ready = 0; mon_ok_addr = '0;
    endtask

    // ---------------- driver ----------------
    logic [7:0] txq[$];

    task automatic idle_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   done;
        done = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int unsigned t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            rdy = bus.rx_ready;
            @(posedge clk);
            #2;
            done = rdy;
        end
        if (!done) check("byte_accept_bound", 0, 1);
    endtask

    task automatic send_txq(input int unsigned maxgap);
        int unsigned gap;
        while (txq.size() > 0) begin
            send_byte(txq.pop_front());
            gap = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
            if (gap > 0 && txq.size() > 0) begin
                bus.rx_valid = 1'b0;
                idle_cycles(gap);
            end
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic rand_frame();
        int unsigned kind;
        int unsigned k;
        logic [7:0]  a, d, c;
        kind = $urandom_range(0, 6);
        a    = 8'($urandom_range(0, NB - 1));
        d    = 8'($urandom);
        case (kind)
            0: txq = '{8'hA5, 8'h01, a, d, 8'h01 ^ a ^ d};
            1: txq = '{8'hA5, 8'h02, d, 8'h02 ^ d};
            2: begin
                c   = 8'($urandom_range(1, 255));
                txq = '{8'hA5, 8'h01, a, d, 8'h01 ^ a ^ d ^ c};
            end
            3: begin
                a   = 8'($urandom_range(NB, 255));
                txq = '{8'hA5, 8'h01, a, d, 8'h01 ^ a ^ d};
            end
            4: begin
                c = 8'($urandom);
                if (c == 8'h01 || c == 8'h02) c = 8'h07;
                txq = '{8'hA5, c};
            end
            5: begin
                k = $urandom_range(1, 4);
                for (int unsigned i = 0; i < k; i++) begin
                    c = 8'($urandom);
                    if (c == 8'hA5) c = 8'h5A;
                    txq.push_back(c);
                end
            end
            default: begin
                txq = '{8'hA5, 8'h01, a, d};
                k = $urandom_range(0, 3);
                repeat (k) void'(txq.pop_back());
            end
        endcase
        send_txq(3);
        if (kind == 6) idle_cycles(TO + $urandom_range(0, 4));
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        #1 rst = 1'b0;
        #2;
        check("reset_we", bus.we, 0);
        check("reset_addr", bus.addr, 0);
        check("reset_data_out", bus.data_out, 0);
        check("reset_frame_ok", bus.frame_ok, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_err_count", bus.err_count, 0);
        check("reset_rx_ready", bus.rx_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        clear_mon();
        txq = '{8'h00, 8'hFF, 8'h13};
        send_txq(0);
        idle_cycles(3);
        check("garbage_no_err", mon_err_n, 0);

        clear_mon();
        txq = '{8'hA5, 8'h01, 8'h03, 8'h40, 8'h42};
        send_txq(0);
        idle_cycles(4);
        check("single_we_cycles", mon_addr.size(), 1);
        check("single_addr", mon_addr[0], 8'h03);
        check("single_data", mon_data[0], 8'h40);
        check("single_frame_ok", mon_ok_n, 1);
        check("single_err_count", bus.err_count, 0);

        clear_mon();
        txq = '{8'hA5, 8'h02, 8'h20, 8'h22};
        send_txq(0);
        idle_cycles(14);
        check("bcast_we_cycles", mon_addr.size(), 10);
        for (int unsigned k = 0; k < 10; k++) begin
            check("bcast_addr", mon_addr[k], k);
            check("bcast_data", mon_data[k], 8'h20);
        end
        check("bcast_contiguous", mon_cyc[9] - mon_cyc[0], 9);
        check("bcast_frame_ok_n", mon_ok_n, 1);
        check("bcast_frame_ok_addr", mon_ok_addr, 9);
        check("bcast_ready_low", mon_busy_ready, 0);

        clear_mon();
        txq = '{8'hA5, 8'h01, 8'h03, 8'h40, 8'h00};
        send_txq(0);
        idle_cycles(4);
        check("badcsum_no_we", mon_addr.size(), 0);
        check("badcsum_err_n", mon_err_n, 1);
        check("badcsum_err_count", bus.err_count, 1);
        clear_mon();
        txq = '{8'hA5, 8'h01, 8'h03, 8'h40, 8'h42};
        send_txq(0);
        idle_cycles(4);
        check("after_badcsum_we", mon_addr.size(), 1);
        check("after_badcsum_addr", mon_addr[0], 8'h03);

        do_reset();
        clear_mon();
        txq = '{8'hA5, 8'h01, 8'h0A, 8'h40, 8'h4B};
        send_txq(0);
        idle_cycles(4);
        check("badaddr_no_we", mon_addr.size(), 0);
        check("badaddr_err_n", mon_err_n, 1);
        txq = '{8'hA5, 8'h07};
        send_txq(0);
        @(negedge clk);
        check("badcmd_err_next_cycle", bus.frame_err, 1);
        check("badcmd_err_count", bus.err_count, 2);
        @(posedge clk);
        #2;

        txq = '{8'hA5, 8'h01};
        send_txq(0);
        repeat (TO - 1) @(posedge clk);
        @(negedge clk);
        check("timeout_not_early", bus.err_count, 2);
        @(negedge clk);
        check("timeout_err", bus.frame_err, 1);
        check("timeout_err_count", bus.err_count, 3);
        @(posedge clk);
        #2;
        clear_mon();
        txq = '{8'hA5, 8'h01, 8'h05, 8'h77, 8'h73};
        send_txq(0);
        idle_cycles(4);
        check("after_timeout_we", mon_addr.size(), 1);
        check("after_timeout_addr", mon_addr[0], 8'h05);
        check("after_timeout_data", mon_data[0], 8'h77);

        txq = '{8'hA5, 8'h02, 8'h20, 8'h22};
        send_txq(0);
        repeat (3) @(posedge clk);
        #2;
        check("bcast4_we", bus.we, 1);
        check("bcast4_addr", bus.addr, 3);
        rst = 1'b0;
        #1;
        check("midrst_we", bus.we, 0);
        check("midrst_addr", bus.addr, 0);
        check("midrst_data_out", bus.data_out, 0);
        check("midrst_frame_ok", bus.frame_ok, 0);
        check("midrst_frame_err", bus.frame_err, 0);
        check("midrst_err_count", bus.err_count, 0);
        check("midrst_rx_ready", bus.rx_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        clear_mon();
        txq = '{8'hA5, 8'h01, 8'h03, 8'h40, 8'h42};
        send_txq(0);
        idle_cycles(4);
        check("after_midrst_we", mon_addr.size(), 1);
        check("after_midrst_addr", mon_addr[0], 8'h03);

        for (int unsigned f = 0; f < 80; f++) begin
            rand_frame();
            idle_cycles($urandom_range(0, 3));
        end

        for (int unsigned k = 0; k < 260; k++) begin
            txq = '{8'hA5, 8'h07};
            send_txq(0);
        end
        idle_cycles(2);
        check("err_count_saturated", bus.err_count, 255);

        idle_cycles(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time bound exceeded, got no finish, expected finish");
        $fatal(1);
    end

endmodule
